// File: rtl/cpu7_ifu_decq.sv
// cpu7_ifu_decq: decode-to-issue circular buffer, NPORT lanes in and out.
// Up to NPORT pre-decoded instructions are enqueued per cycle. The NPORT oldest
// entries are presented to issue, with lane 0 the oldest.
// Optional macro CPU7_DECQ_PERF_EN adds the decq_stall_cnt refused-cycle counter.
`ifndef LSOC1K_PRU_HINT
`define LSOC1K_PRU_HINT 4
`endif
module cpu7_ifu_decq #(
    parameter int         NPORT        = 3,
    parameter int         DEPTH        = 8,
    parameter int         GRLEN        = 32,
    parameter int         HINT_W       = `LSOC1K_PRU_HINT,
    parameter logic [5:0] EXC_INT_CODE = 6'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        int_except,
    input  logic [NPORT-1:0]            de_valid,
    input  logic [NPORT*GRLEN-1:0]      de_pc,
    input  logic [NPORT*32-1:0]         de_inst,
    input  logic [NPORT*(GRLEN-2)-1:0]  de_br_target,
    input  logic [NPORT-1:0]            de_br_taken,
    input  logic [NPORT-1:0]            de_exception,
    input  logic [NPORT*6-1:0]          de_exccode,
    input  logic [NPORT*HINT_W-1:0]     de_hint,
    output logic [NPORT-1:0]            de_accept,
    output logic                        de_allow_in,
    output logic [NPORT-1:0]            is_valid,
    output logic [NPORT*GRLEN-1:0]      is_pc,
    output logic [NPORT*32-1:0]         is_inst,
    output logic [NPORT*(GRLEN-2)-1:0]  is_br_target,
    output logic [NPORT-1:0]            is_br_taken,
    output logic [NPORT-1:0]            is_exception,
    output logic [NPORT*6-1:0]          is_exccode,
    output logic [NPORT*HINT_W-1:0]     is_hint,
    input  logic [NPORT-1:0]            is_accept,
    output logic [$clog2(DEPTH):0]      decq_count
`ifdef CPU7_DECQ_PERF_EN
    ,
    output logic [31:0]                 decq_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [GRLEN-1:0]  pc;
        logic [31:0]       inst;
        logic [GRLEN-3:0]  tgt;
        logic              taken;
        logic              exc;
        logic [5:0]        code;
        logic [HINT_W-1:0] hint;
    } ent_t;

    ent_t             mem_q [DEPTH];
    ent_t             de_ent [NPORT];
    ent_t             is_ent [NPORT];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, free, n_push, n_pop;
    logic             lead_in, lead_out;

    // Space is judged from registered occupancy only; same-cycle pops never add room.
    assign free        = CNT_W'(DEPTH) - count_q;
    assign de_allow_in = free >= CNT_W'(NPORT);
    assign decq_count  = count_q;

    // Unpack the de lanes and accept the contiguous valid prefix that fits.
    always_comb begin
        de_accept = '0;
        n_push    = '0;
        lead_in   = 1'b1;
        for (int i = 0; i < NPORT; i++) begin
            de_ent[i].pc    = de_pc[i*GRLEN +: GRLEN];
            de_ent[i].inst  = de_inst[i*32 +: 32];
            de_ent[i].tgt   = de_br_target[i*(GRLEN-2) +: (GRLEN-2)];
            de_ent[i].taken = de_br_taken[i];
            de_ent[i].exc   = de_exception[i];
            de_ent[i].code  = de_exccode[i*6 +: 6];
            de_ent[i].hint  = de_hint[i*HINT_W +: HINT_W];
            lead_in         = lead_in & de_valid[i];
            de_accept[i]    = lead_in && (CNT_W'(i) < free) && !flush && !rst;
            n_push          = n_push + CNT_W'(de_accept[i]);
        end
    end

    // Present the oldest entries, apply interrupt tagging on lane 0, count pops.
    always_comb begin
        is_pc        = '0;
        is_inst      = '0;
        is_br_target = '0;
        is_br_taken  = '0;
        is_exception = '0;
        is_exccode   = '0;
        is_hint      = '0;
        is_valid     = '0;
        n_pop        = '0;
        lead_out     = 1'b1;
        for (int k = 0; k < NPORT; k++) begin
            is_ent[k]   = mem_q[head_q + PTR_W'(k)];
            is_valid[k] = CNT_W'(k) < count_q;
            is_pc[k*GRLEN +: GRLEN]               = is_ent[k].pc;
            is_inst[k*32 +: 32]                   = is_ent[k].inst;
            is_br_target[k*(GRLEN-2) +: (GRLEN-2)] = is_ent[k].tgt;
            is_br_taken[k]                        = is_ent[k].taken;
            is_exception[k]                       = is_valid[k] & is_ent[k].exc;
            is_exccode[k*6 +: 6]                  = is_ent[k].code;
            is_hint[k*HINT_W +: HINT_W]           = is_ent[k].hint;
            if (k == 0 && is_valid[0] && int_except) begin
                is_exception[0] = 1'b1;
                is_exccode[5:0] = EXC_INT_CODE;
            end
            lead_out = lead_out & is_accept[k] & is_valid[k];
            n_pop    = n_pop + CNT_W'(lead_out);
        end
    end

    // Next pointer/occupancy state; flush and reset both empty the queue.
    always_comb begin
        head_d  = head_q + PTR_W'(n_pop);
        tail_d  = tail_q + PTR_W'(n_push);
        count_d = count_q + n_push - n_pop;
        if (rst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    // Payload RAM, written in lane order from tail; deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++)
            if (de_accept[i]) mem_q[tail_q + PTR_W'(i)] <= de_ent[i];
    end

`ifdef CPU7_DECQ_PERF_EN
    logic [31:0] stall_q;
    assign decq_stall_cnt = stall_q;

    // Saturating count of cycles where the de stage offered lane 0 and was refused.
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (de_valid[0] && !de_accept[0] && !flush && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_cpu7_ifu_decq.sv
// Randomized bench for cpu7_ifu_decq against a queue-based reference model.
module tb_cpu7_ifu_decq;
  localparam int NPORT = 3, DEPTH = 8, GRLEN = 32, HINT_W = 4;

  typedef struct {
    logic [GRLEN-1:0]  pc;
    logic [31:0]       inst;
    logic [GRLEN-3:0]  tgt;
    logic              taken;
    logic              exc;
    logic [5:0]        code;
    logic [HINT_W-1:0] hint;
  } ent_t;

  logic clk = 1'b0, rst, flush, int_except;
  logic [NPORT-1:0]           de_valid, de_br_taken, de_exception, de_accept;
  logic [NPORT*GRLEN-1:0]     de_pc, is_pc;
  logic [NPORT*32-1:0]        de_inst, is_inst;
  logic [NPORT*(GRLEN-2)-1:0] de_br_target, is_br_target;
  logic [NPORT*6-1:0]         de_exccode, is_exccode;
  logic [NPORT*HINT_W-1:0]    de_hint, is_hint;
  logic [NPORT-1:0]           is_valid, is_br_taken, is_exception, is_accept;
  logic                       de_allow_in;
  logic [$clog2(DEPTH):0]     decq_count;
`ifdef CPU7_DECQ_PERF_EN
  logic [31:0]                decq_stall_cnt;
  logic [31:0]                m_stall = 0;
`endif

  ent_t q[$];
  ent_t cur[NPORT];
  int n_chk = 0, n_pass = 0;

  cpu7_ifu_decq #(.NPORT(NPORT), .DEPTH(DEPTH), .GRLEN(GRLEN), .HINT_W(HINT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .int_except(int_except),
    .de_valid(de_valid), .de_pc(de_pc), .de_inst(de_inst), .de_br_target(de_br_target),
    .de_br_taken(de_br_taken), .de_exception(de_exception), .de_exccode(de_exccode),
    .de_hint(de_hint), .de_accept(de_accept), .de_allow_in(de_allow_in),
    .is_valid(is_valid), .is_pc(is_pc), .is_inst(is_inst), .is_br_target(is_br_target),
    .is_br_taken(is_br_taken), .is_exception(is_exception), .is_exccode(is_exccode),
    .is_hint(is_hint), .is_accept(is_accept), .decq_count(decq_count)
`ifdef CPU7_DECQ_PERF_EN
    , .decq_stall_cnt(decq_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One cycle: drive, check against the model before the edge, then advance the model.
  task automatic run(input int nv, input logic [NPORT-1:0] acc, input logic fl,
                     input logic r, input logic irq, input logic [31:0] pcbase, input bit do_chk);
    int free, npush, npop, sz;
    logic [NPORT-1:0] exp_acc;
    for (int k = 0; k < NPORT; k++) begin
      cur[k].pc    = (pcbase != 0) ? pcbase + 32'(4*k) : $urandom;
      cur[k].inst  = $urandom;
      cur[k].tgt   = 30'($urandom);
      cur[k].taken = 1'($urandom);
      cur[k].exc   = ($urandom_range(0, 7) == 0);
      cur[k].code  = 6'($urandom);
      cur[k].hint  = 4'($urandom);
      de_valid[k]  = (k < nv);
      de_pc[k*GRLEN +: GRLEN]               = cur[k].pc;
      de_inst[k*32 +: 32]                   = cur[k].inst;
      de_br_target[k*(GRLEN-2) +: (GRLEN-2)] = cur[k].tgt;
      de_br_taken[k]                        = cur[k].taken;
      de_exception[k]                       = cur[k].exc;
      de_exccode[k*6 +: 6]                  = cur[k].code;
      de_hint[k*HINT_W +: HINT_W]           = cur[k].hint;
    end
    is_accept = acc; flush = fl; rst = r; int_except = irq;
    sz    = q.size();
    free  = DEPTH - sz;
    npush = (fl || r) ? 0 : ((nv < free) ? nv : free);
    exp_acc = NPORT'((1 << npush) - 1);
    #3;
    if (do_chk) begin
      chk("count", 64'(decq_count), 64'(sz));
      chk("allow_in", 64'(de_allow_in), 64'(free >= NPORT));
      chk("de_accept", 64'(de_accept), 64'(exp_acc));
`ifdef CPU7_DECQ_PERF_EN
      chk("stall_cnt", 64'(decq_stall_cnt), 64'(m_stall));
`endif
      for (int k = 0; k < NPORT; k++) begin
        chk($sformatf("valid%0d", k), 64'(is_valid[k]), 64'(k < sz));
        if (k < sz) begin
          chk($sformatf("pc%0d", k), 64'(is_pc[k*GRLEN +: GRLEN]), 64'(q[k].pc));
          chk($sformatf("inst%0d", k), 64'(is_inst[k*32 +: 32]), 64'(q[k].inst));
          chk($sformatf("tgt%0d", k), 64'(is_br_target[k*(GRLEN-2) +: (GRLEN-2)]), 64'(q[k].tgt));
          chk($sformatf("taken%0d", k), 64'(is_br_taken[k]), 64'(q[k].taken));
          chk($sformatf("hint%0d", k), 64'(is_hint[k*HINT_W +: HINT_W]), 64'(q[k].hint));
          chk($sformatf("exc%0d", k), 64'(is_exception[k]), 64'((k == 0 && irq) || q[k].exc));
          chk($sformatf("code%0d", k), 64'(is_exccode[k*6 +: 6]),
              (k == 0 && irq) ? 64'h0 : 64'(q[k].code));
        end else begin
          chk($sformatf("exc_inv%0d", k), 64'(is_exception[k]), 64'h0);
        end
      end
    end
    npop = 0;
    while (npop < NPORT && npop < sz && acc[npop]) npop++;
    @(posedge clk);
`ifdef CPU7_DECQ_PERF_EN
    if (r) m_stall = 0;
    else if (nv > 0 && npush == 0 && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
    if (r || fl) q.delete();
    else begin
      for (int p = 0; p < npop; p++) void'(q.pop_front());
      for (int i = 0; i < npush; i++) q.push_back(cur[i]);
    end
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    run(0, '0, 1'b0, 1'b1, 1'b0, 0, 1'b0);               // bring out of X
    run(3, '0, 1'b0, 1'b1, 1'b0, 0, 1'b1);               // reset state, no accept
    run(3, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1c00_0000, 1'b1);
    for (int c = 0; c < 4; c++) run(3, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b1);  // fill to full
    for (int c = 0; c < 8; c++) run(3, 3'b111, 1'b0, 1'b0, 1'b0, 0, 1'b1);  // wrap
    run(0, 3'b111, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run(0, 3'b111, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run(3, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run(0, 3'b101, 1'b0, 1'b0, 1'b0, 0, 1'b1);           // non-thermometer accept
    run(3, 3'b000, 1'b0, 1'b0, 1'b1, 0, 1'b1);           // interrupt tag
    run(3, 3'b000, 1'b1, 1'b0, 1'b0, 0, 1'b1);           // flush
    run(3, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      run($urandom_range(0, NPORT),
          (c < 300) ? NPORT'($urandom & $urandom) : NPORT'($urandom | $urandom),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) == 0), 0, 1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
